// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one add-3 + shift per clock).
// Latency: start accepted at edge N -> done pulse and new digits in the cycle after edge N+BIN_WIDTH.
// Backpressure: none; start is ignored while busy, accepted in IDLE and in the DONE cycle (back-to-back).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      conversion request, sampled only when not busy
//   binary     value to convert, captured on the accepted start edge
//   busy       high while a conversion is in progress
//   done       one-cycle pulse on the cycle the digit outputs update
//   thousands/hundreds/tens/units   registered BCD result, held until the next conversion completes
//   blank      leading-zero blank mask (bit3 = thousands), present only when
//              BCD_BLANK_LEADING_ZERO_EN is defined
//
// Parameter BIN_WIDTH: 1..13, so the result always fits in four BCD digits.

module bcd_seq_converter #(
  parameter int BIN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] binary,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           thousands,
  output logic [3:0]           hundreds,
  output logic [3:0]           tens,
  output logic [3:0]           units
`ifdef BCD_BLANK_LEADING_ZERO_EN
  ,
  output logic [3:0]           blank
`endif
);

  // Wide enough to hold the iteration count BIN_WIDTH itself.
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  if (BIN_WIDTH < 1 || BIN_WIDTH > 13) begin : g_width_check
    $error("bcd_seq_converter: BIN_WIDTH must be in 1..13");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] shift;     // remaining binary bits, MSB first
  logic [15:0]          scratch;   // four BCD digits under construction
  logic [CNT_W-1:0]     cnt;       // iterations still to run

  logic [15:0]          scratch_adj;
  logic [15:0]          scratch_nxt;

  // Per-nibble add-3 correction. Nibbles are independent: a digit >=5 becomes
  // 8..12, so the following shift carries it into the next digit naturally.
  function automatic logic [15:0] add3(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

`ifdef BCD_BLANK_LEADING_ZERO_EN
  // Blank a digit only if it and every more significant digit are zero;
  // units is never blanked so a zero result still shows "0".
  function automatic logic [3:0] blank_of(input logic [15:0] d);
    logic b3, b2, b1;
    b3 = (d[15:12] == 4'd0);
    b2 = b3 & (d[11:8] == 4'd0);
    b1 = b2 & (d[7:4] == 4'd0);
    return {b3, b2, b1, 1'b0};
  endfunction
`endif

  // One double-dabble step: correct, then shift the next binary MSB into bit 0.
  always_comb begin
    scratch_adj = add3(scratch);
    scratch_nxt = (scratch_adj << 1) | {15'd0, shift[BIN_WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift     <= '0;
      scratch   <= '0;
      cnt       <= '0;
      thousands <= 4'd0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      units     <= 4'd0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
      blank     <= 4'b1110;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back
        // conversions every BIN_WIDTH+1 cycles.
        IDLE, DONE: begin
          if (start) begin
            shift   <= binary;
            scratch <= '0;
            cnt     <= CNT_W'(BIN_WIDTH);
            busy    <= 1'b1;
            state   <= CONVERT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        CONVERT: begin
          scratch <= scratch_nxt;
          shift   <= shift << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Last step: publish the finished digits on this same edge so
            // they are already valid during the done cycle.
            thousands <= scratch_nxt[15:12];
            hundreds  <= scratch_nxt[11:8];
            tens      <= scratch_nxt[7:4];
            units     <= scratch_nxt[3:0];
`ifdef BCD_BLANK_LEADING_ZERO_EN
            blank     <= blank_of(scratch_nxt);
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
